// File: rtl/reorder_logic_sequencer_if.sv
// Bus between the re-order sequencer, its selector and the downstream sink.
// Handshake semantics (both directions): a transfer happens on a rising edge
// where the producer's valid and the consumer's ready are both high; the
// producer holds its payload stable while valid is high and ready is low.
// Selector side: the sequencer presents valid_o/next_o, the selector answers
// with a one-hot ack_i on next_o, accepted only while ready_o is high.
// Downstream side: out_valid_o/out_data_o/out_id_o against out_ready_i.
interface reorder_logic_sequencer_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);

    logic                             enable_i;
    logic                             flush_i;
    logic [NUM_QUEUES-1:0]            ack_i;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] data_i;
    logic                             ready_o;
    logic                             valid_o;
    logic [SEL_WIDTH-1:0]             next_o;
    logic                             out_valid_o;
    logic [DATA_WIDTH-1:0]            out_data_o;
    logic [SEL_WIDTH-1:0]             out_id_o;
    logic                             out_ready_i;
    logic                             err_o;
    logic                             stall_o;
    logic [1:0]                       state_o;

    // Sequencer view.
    modport slave (
        input  enable_i, flush_i, ack_i, data_i, out_ready_i,
        output ready_o, valid_o, next_o, out_valid_o, out_data_o, out_id_o,
        output err_o, stall_o, state_o
    );

    // Environment view (selector + downstream + control).
    modport master (
        output enable_i, flush_i, ack_i, data_i, out_ready_i,
        input  ready_o, valid_o, next_o, out_valid_o, out_data_o, out_id_o,
        input  err_o, stall_o, state_o
    );
endinterface

// File: rtl/reorder_logic_sequencer.sv
// Re-order sequencer: holds the expected-next queue pointer, accepts the
// selector's pull-acknowledge for that queue only, captures the queue head into
// a one-entry output register and hands it downstream. Round-robin order
// 0..NUM_QUEUES-1 is enforced; any other acknowledge raises a sticky error.
// Optional stall watchdog: define REORDER_LOGIC_WATCHDOG_EN.
module reorder_logic_sequencer #(
    parameter int NUM_QUEUES  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input logic                        clk_i,
    input logic                        arst_n_i,
    reorder_logic_sequencer_if.slave   bus
);
    localparam int SEL_WIDTH = $clog2(NUM_QUEUES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    next_q, next_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]    out_id_q, out_id_d;
    logic                    err_q, err_d;
    logic                    stall_q, stall_d;

    logic                    ready;
    logic                    accept;
    logic                    drain_done;
    logic [NUM_QUEUES-1:0]   ack_expected;

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FSM next state: flush wins over enable; DRAIN ends once the register empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.flush_i) state_d = ST_DRAIN;
                      else if (bus.enable_i) state_d = ST_RUN;
            ST_RUN:   if (bus.flush_i) state_d = ST_DRAIN;
                      else if (!bus.enable_i) state_d = ST_IDLE;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and acknowledge qualification.
    always_comb begin
        ready        = !out_valid_q || bus.out_ready_i;
        ack_expected = NUM_QUEUES'(1) << next_q;
        accept       = (state_q == ST_RUN) && ready && (bus.ack_i == ack_expected);
        // No capture happens in DRAIN, so the register is empty after this
        // edge exactly when it is empty now or being consumed now.
        drain_done   = (state_q == ST_DRAIN) && ready;
    end

    // Datapath: capture on accept, release on downstream transfer, sticky error.
    always_comb begin
        next_d      = next_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        err_d       = err_q;
        if (accept) begin
            out_data_d  = bus.data_i[int'(next_q)*DATA_WIDTH +: DATA_WIDTH];
            out_id_d    = next_q;
            out_valid_d = 1'b1;
            next_d      = (next_q == SEL_WIDTH'(NUM_QUEUES-1)) ? '0 : next_q + 1'b1;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if ((bus.ack_i != '0) && !accept) err_d = 1'b1;
        if (drain_done) begin
            next_d = '0;
            err_d  = 1'b0;
        end
    end

`ifdef REORDER_LOGIC_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0] wdog_q, wdog_d;

    // Watchdog: count idle-but-ready RUN cycles, saturate, flag stall sticky.
    always_comb begin
        wdog_d  = wdog_q;
        stall_d = stall_q;
        if (accept || (state_d != ST_RUN)) begin
            wdog_d = '0;
        end else if ((state_q == ST_RUN) && ready && (bus.ack_i == '0) &&
                     (wdog_q != CNT_W'(WDOG_CYCLES))) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (wdog_d == CNT_W'(WDOG_CYCLES)) stall_d = 1'b1;
        if (drain_done) begin
            stall_d = 1'b0;
            wdog_d  = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) wdog_q <= '0;
        else           wdog_q <= wdog_d;
    end
`else
    // Watchdog absent: stall never asserts.
    always_comb begin
        stall_d = 1'b0;
    end
`endif

    // Datapath and flag registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            next_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            next_q      <= next_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = (state_q == ST_RUN);
    assign bus.next_o      = next_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_id_o    = out_id_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = stall_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_reorder_logic_sequencer.sv
// Bench for reorder_logic_sequencer with three queues and an 8-cycle watchdog.
module tb_reorder_logic_sequencer;
    localparam int NQ = 3;
    localparam int DW = 16;
    localparam int WD = 8;
    localparam int SW = 2;
`ifdef REORDER_LOGIC_WATCHDOG_EN
    localparam logic EXP_STALL = 1'b1;
`else
    localparam logic EXP_STALL = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reorder_logic_sequencer_if #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW)) bus ();
    reorder_logic_sequencer #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .WDOG_CYCLES(WD)) dut (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // driver
    task automatic drive(input logic en, input logic fl, input logic [NQ-1:0] ack, input logic ordy);
        bus.enable_i    = en;
        bus.flush_i     = fl;
        bus.ack_i       = ack;
        bus.out_ready_i = ordy;
    endtask

    // reference model: pointer, one-slot output buffer, sticky flags
    int              m_mode;   // 0 idle, 1 run, 2 drain
    int              m_ptr;
    logic            m_ov;
    logic [DW-1:0]   m_data;
    int              m_id;
    logic            m_err;
    logic            m_stall;
    int              m_cnt;

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_ov = 0; m_data = '0; m_id = 0;
        m_err = 0; m_stall = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic rdy, acc;
        logic [NQ-1:0] want;
        int nmode;
        rdy  = !m_ov || bus.out_ready_i;
        want = '0;
        want[m_ptr] = 1'b1;
        acc  = (m_mode == 1) && rdy && (bus.ack_i == want);
        if (bus.ack_i != '0 && !acc) m_err = 1'b1;
        if (m_mode == 1 && rdy && bus.ack_i == '0 && m_cnt < WD) m_cnt++;
        if (acc) begin
            m_cnt  = 0;
            m_data = bus.data_i[m_ptr*DW +: DW];
            m_id   = m_ptr;
            m_ov   = 1'b1;
            m_ptr  = (m_ptr + 1) % NQ;
        end else if (bus.out_ready_i) begin
            m_ov = 1'b0;
        end
        if (m_mode == 2) begin
            if (!m_ov) begin
                nmode = 0; m_ptr = 0; m_err = 0; m_stall = 0; m_cnt = 0;
            end else nmode = 2;
        end else if (bus.flush_i) nmode = 2;
        else if (m_mode == 0 && bus.enable_i) nmode = 1;
        else if (m_mode == 1 && !bus.enable_i) nmode = 0;
        else nmode = m_mode;
        if (nmode != 1) m_cnt = 0;
        if (m_cnt == WD && EXP_STALL) m_stall = 1'b1;
        m_mode = nmode;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"},     32'(bus.ready_o),     32'(!m_ov || bus.out_ready_i));
        chk({tag, ".valid"},     32'(bus.valid_o),     32'(m_mode == 1));
        chk({tag, ".next"},      32'(bus.next_o),      32'(m_ptr));
        chk({tag, ".out_valid"}, 32'(bus.out_valid_o), 32'(m_ov));
        chk({tag, ".out_data"},  32'(bus.out_data_o),  32'(m_data));
        chk({tag, ".out_id"},    32'(bus.out_id_o),    32'(m_id));
        chk({tag, ".err"},       32'(bus.err_o),       32'(m_err));
        chk({tag, ".stall"},     32'(bus.stall_o),     32'(m_stall));
    endtask

    // directed vector table
    typedef struct {
        logic en; logic fl; logic [NQ-1:0] ack; logic ordy;
        logic exp_rdy; logic exp_vld;
        logic exp_ov; logic [SW-1:0] exp_id; logic [SW-1:0] exp_next; logic exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic en, input logic fl, input logic [NQ-1:0] ack, input logic ordy,
                       input logic rdy, input logic vld, input logic ov, input logic [SW-1:0] id,
                       input logic [SW-1:0] nxt, input logic err, input logic [DW-1:0] data);
        vec_t v;
        v.en = en; v.fl = fl; v.ack = ack; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_vld = vld; v.exp_ov = ov; v.exp_id = id;
        v.exp_next = nxt; v.exp_err = err; v.exp_data = data;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        drive(0, 0, '0, 1);
        bus.data_i = {16'hA222, 16'hA111, 16'hA000};

        // reset state
        #1;
        model_reset();
        check_model("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //   en fl ack     ordy  rdy vld  ov id next err data
        add(1, 0, 3'b000, 1,    1, 0,   0, 0, 0, 0, 16'h0000);
        add(1, 0, 3'b001, 1,    1, 1,   1, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b010, 1,    1, 1,   1, 1, 2, 0, 16'hA111);
        add(1, 0, 3'b100, 1,    1, 1,   1, 2, 0, 0, 16'hA222);
        add(1, 0, 3'b001, 1,    1, 1,   1, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b010, 1,    1, 1,   1, 1, 2, 0, 16'hA111);
        add(1, 0, 3'b100, 1,    1, 1,   1, 2, 0, 0, 16'hA222);
        add(1, 0, 3'b001, 1,    1, 1,   1, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b000, 1,    1, 1,   0, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b010, 1,    1, 1,   1, 1, 2, 0, 16'hA111);
        add(1, 0, 3'b000, 0,    0, 1,   1, 1, 2, 0, 16'hA111);
        add(1, 0, 3'b000, 0,    0, 1,   1, 1, 2, 0, 16'hA111);
        add(1, 0, 3'b100, 1,    1, 1,   1, 2, 0, 0, 16'hA222);
        add(1, 0, 3'b000, 1,    1, 1,   0, 2, 0, 0, 16'hA222);
        add(1, 0, 3'b001, 1,    1, 1,   1, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b000, 1,    1, 1,   0, 0, 1, 0, 16'hA000);
        add(1, 0, 3'b100, 1,    1, 1,   0, 0, 1, 1, 16'hA000);
        add(1, 0, 3'b010, 1,    1, 1,   1, 1, 2, 1, 16'hA111);
        add(1, 0, 3'b000, 0,    0, 1,   1, 1, 2, 1, 16'hA111);
        add(1, 1, 3'b000, 0,    0, 1,   1, 1, 2, 1, 16'hA111);
        add(1, 0, 3'b000, 0,    0, 0,   1, 1, 2, 1, 16'hA111);
        add(1, 0, 3'b000, 1,    1, 0,   0, 1, 0, 0, 16'hA111);
        add(1, 0, 3'b000, 1,    1, 0,   0, 1, 0, 0, 16'hA111);
        add(1, 0, 3'b001, 1,    1, 1,   1, 0, 1, 0, 16'hA000);

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].en, tbl[i].fl, tbl[i].ack, tbl[i].ordy);
            #1;
            chk({t, ".ready"}, 32'(bus.ready_o), 32'(tbl[i].exp_rdy));
            chk({t, ".valid"}, 32'(bus.valid_o), 32'(tbl[i].exp_vld));
            @(posedge clk);
            #1;
            chk({t, ".out_valid"}, 32'(bus.out_valid_o), 32'(tbl[i].exp_ov));
            chk({t, ".out_id"},    32'(bus.out_id_o),    32'(tbl[i].exp_id));
            chk({t, ".next"},      32'(bus.next_o),      32'(tbl[i].exp_next));
            chk({t, ".err"},       32'(bus.err_o),       32'(tbl[i].exp_err));
            chk({t, ".out_data"},  32'(bus.out_data_o),  32'(tbl[i].exp_data));
        end

        // asynchronous reset while an entry is held
        drive(1, 0, '0, 0);
        #2;
        chk("areset.pre_out_valid", 32'(bus.out_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("areset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // watchdog: RUN with no acknowledge
        drive(1, 0, '0, 1);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (e == 8) chk("wdog.before", 32'(bus.stall_o), 32'd0);
            if (e == 9) begin
                chk("wdog.stall", 32'(bus.stall_o), 32'(EXP_STALL));
                chk("wdog.valid", 32'(bus.valid_o), 32'd1);
            end
        end
        drive(1, 1, '0, 1);
        @(posedge clk);
        #1;
        drive(0, 0, '0, 1);
        @(posedge clk);
        #1;
        chk("wdog.clear_stall", 32'(bus.stall_o), 32'd0);
        chk("wdog.clear_valid", 32'(bus.valid_o), 32'd0);

        // randomized run against the model
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [NQ-1:0] a;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_model("rnd_rst");
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            r = $urandom_range(0, 19);
            if (r < 12) begin
                a = '0;
                a[m_ptr] = 1'b1;
            end else if (r < 19) a = '0;
            else a = NQ'($urandom_range(1, (1 << NQ) - 1));
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, a,
                  $urandom_range(0, 3) != 0);
            bus.data_i = {16'($urandom), 16'($urandom), 16'($urandom)};
            #1;
            check_model($sformatf("rnd%0d", c));
            model_step();
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
